// File: rtl/fir_pkg.sv
// Shared constants, state encoding and width helpers for the filter subsystem.
package fir_pkg;

  localparam int TAPS_DEF  = 32;
  localparam int WIN_DEF   = 8;
  localparam int WCOEF_DEF = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_DONE = 2'd2
  } fir_state_t;

  function automatic int clog2(input int unsigned v);
    int          r;
    int unsigned x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

  // Full-precision accumulator: product width plus one bit per doubling of taps.
  function automatic int acc_width(input int taps, input int win, input int wcoef);
    return win + wcoef + clog2(taps);
  endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// Signed multiply with a sign-extended full-precision accumulator; clr beats en.
module fir_mac_unit
  import fir_pkg::*;
#(
  parameter int WIN   = WIN_DEF,
  parameter int WCOEF = WCOEF_DEF,
  parameter int ACC_W = acc_width(TAPS_DEF, WIN_DEF, WCOEF_DEF)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIN-1:0]   a,
  input  logic [WCOEF-1:0] b,
  output logic [ACC_W-1:0] acc
);

  localparam int WP = WIN + WCOEF;

  logic signed [WP-1:0] w_prod;
  logic [ACC_W-1:0]     w_prod_ext;
  logic [ACC_W-1:0]     r_acc;

  assign w_prod     = $signed(a) * $signed(b);
  assign w_prod_ext = {{(ACC_W - WP){w_prod[WP-1]}}, w_prod};

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_acc <= '0;
    end else if (en) begin
      r_acc <= r_acc + w_prod_ext;
    end
  end

  assign acc = r_acc;

endmodule

// File: rtl/fir_tdm_sequencer.sv
// Time-multiplexed FIR: one MAC per tap per cycle over a circular sample buffer
// and a run-time-loadable coefficient bank, with valid/ready on both sides.
module fir_tdm_sequencer
  import fir_pkg::*;
#(
  parameter int TAPS  = TAPS_DEF,
  parameter int WIN   = WIN_DEF,
  parameter int WCOEF = WCOEF_DEF,
  parameter int ACC_W = acc_width(TAPS, WIN, WCOEF),
  localparam int AW   = clog2(TAPS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIN-1:0]   in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [ACC_W-1:0] out_data,
  input  logic             out_ready,
  input  logic             coef_we,
  input  logic [AW-1:0]    coef_addr,
  input  logic [WCOEF-1:0] coef_wdata,
  output logic             busy
);

  fir_state_t       r_state;
  fir_state_t       w_next;
  logic [AW-1:0]    r_head;
  logic [AW-1:0]    r_k;
  logic [AW-1:0]    w_wr_idx;
  logic [AW-1:0]    w_rd_idx;
  logic [WIN-1:0]   r_buf  [TAPS];
  logic [WCOEF-1:0] r_coef [TAPS];
  logic             w_accept;
  logic             w_coef_take;
  logic             w_mac_clr;
  logic             w_mac_en;
  logic [ACC_W-1:0] w_acc;

  // Head points at the newest sample, so tap k reads head-k with natural wrap.
  assign w_wr_idx = r_head + 1'b1;
  assign w_rd_idx = r_head - r_k;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b1;
    w_accept    = 1'b0;
    w_coef_take = 1'b0;
    w_mac_clr   = 1'b0;
    w_mac_en    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          w_accept  = 1'b1;
          w_mac_clr = 1'b1;
          w_next    = ST_MAC;
        end else begin
          w_coef_take = coef_we;
        end
      end
      ST_MAC: begin
        w_mac_en = 1'b1;
        if (r_k == AW'(TAPS - 1)) begin
          w_next = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head <= '0;
      r_k    <= '0;
      r_buf  <= '{default: '0};
      r_coef <= '{default: '0};
    end else begin
      if (w_accept) begin
        r_buf[w_wr_idx] <= in_data;
        r_head          <= w_wr_idx;
        r_k             <= '0;
      end
      if (w_mac_en) begin
        r_k <= r_k + 1'b1;
      end
      if (w_coef_take) begin
        r_coef[coef_addr] <= coef_wdata;
      end
    end
  end

  fir_mac_unit #(
    .WIN  (WIN),
    .WCOEF(WCOEF),
    .ACC_W(ACC_W)
  ) u_mac (
    .clk(clk),
    .rst(rst),
    .clr(w_mac_clr),
    .en (w_mac_en),
    .a  (r_buf[w_rd_idx]),
    .b  (r_coef[r_k]),
    .acc(w_acc)
  );

  assign out_data = w_acc;

endmodule
